// File: rtl/cnt161_seq_if.sv
// Bundle between the cnt161_seq sequencer and its user / 4-bit counter.
// rpt carries the interval repeat count R.
interface cnt161_seq_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic         stop;
  logic         pause;
  logic         mode;
  logic [3:0]   preset;
  logic [W-1:0] rpt;
  logic         tc;
  logic         pe;
  logic [3:0]   d;
  logic         cep;
  logic         cet;
  logic         busy;
  logic         done;
  logic [W-1:0] wraps;

  modport master (
    output start, stop, pause, mode, preset, rpt, tc,
    input  pe, d, cep, cet, busy, done, wraps
  );

  modport slave (
    input  start, stop, pause, mode, preset, rpt, tc,
    output pe, d, cep, cet, busy, done, wraps
  );
endinterface

// File: rtl/cnt161_seq.sv
// Sequencer driving a 4-bit synchronous counter: R segments of (16 - preset) counts
// plus a reload cycle each, with a one-cycle done pulse per interval.
module cnt161_seq #(
  parameter int unsigned W = 8
) (
  input  logic        CP,
  input  logic        CR,
  cnt161_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   preset_q, preset_d;
  logic [W-1:0] rpt_q, rpt_d;
  logic [W-1:0] wraps_q, wraps_d;
  logic         done_q, done_d;
  logic [W-1:0] wraps_inc;
  logic         cep;
  logic         wrap;

  // cep is the only combinational output so pause takes effect in the same cycle.
  assign cep       = (state_q == StRun) & ~bus.pause;
  assign wrap      = cep & bus.tc;
  assign wraps_inc = wraps_q + W'(1);

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    rpt_d    = rpt_q;
    wraps_d  = wraps_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          preset_d = bus.preset;
          rpt_d    = bus.rpt;
          wraps_d  = '0;
          if (bus.rpt == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: state_d = StRun;
      StRun: begin
        if (wrap) begin
          wraps_d = wraps_inc;
          if (wraps_inc == rpt_q) begin
            done_d = 1'b1;
            if (bus.mode) begin
              wraps_d = '0;
              state_d = StLoad;
            end else begin
              state_d = StDone;
            end
          end else begin
            state_d = StLoad;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // stop wins everywhere; wraps is frozen for readout and start is not latched.
    if (bus.stop) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      wraps_d  = wraps_q;
      preset_d = preset_q;
      rpt_d    = rpt_q;
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_q  <= StIdle;
      preset_q <= '0;
      rpt_q    <= '0;
      wraps_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      rpt_q    <= rpt_d;
      wraps_q  <= wraps_d;
      done_q   <= done_d;
    end
  end

  assign bus.pe    = (state_q != StLoad);
  assign bus.d     = preset_q;
  assign bus.cet   = (state_q == StRun);
  assign bus.cep   = cep;
  assign bus.busy  = (state_q == StLoad) | (state_q == StRun);
  assign bus.done  = done_q;
  assign bus.wraps = wraps_q;

endmodule

// File: tb/tb_cnt161_seq.sv
// Directed bench for cnt161_seq with a behavioural 4-bit counter closing the tc loop.
module tb_cnt161_seq;
  localparam int unsigned W = 8;

  logic       CP;
  logic       CR;
  logic [3:0] q;
  int         n_cmp;
  int         n_bad;

  cnt161_seq_if #(.W(W)) bus ();

  cnt161_seq #(.W(W)) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // Counter model: async clear, sync load, count on CEP & CET.
  always @(posedge CP or negedge CR) begin
    if (!CR) q <= 4'd0;
    else if (!bus.pe) q <= bus.d;
    else if (bus.cep && bus.cet) q <= q + 4'd1;
  end
  assign bus.tc = (q == 4'd15) && bus.cet;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CP);
      #1;
    end
  endtask

  task automatic go(input logic [3:0] p, input logic [W-1:0] r, input logic m);
    bus.preset = p;
    bus.rpt    = r;
    bus.mode   = m;
    bus.start  = 1'b1;
    tick(1);
    bus.start  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    CR = 1'b0;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.mode = 0;
    bus.preset = 4'd0; bus.rpt = '0;
    #2;
    chk("rst_pe", 32'(bus.pe), 32'd1);
    chk("rst_cep", 32'(bus.cep), 32'd0);
    chk("rst_cet", 32'(bus.cet), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wraps", 32'(bus.wraps), 32'd0);
    chk("rst_d", 32'(bus.d), 32'd0);
    @(negedge CP);
    CR = 1'b1;
    tick(1);

    // One-shot p=12 R=1
    go(4'd12, 8'd1, 1'b0);                     // after edge 0
    chk("os1_pe", 32'(bus.pe), 32'd0);
    chk("os1_d", 32'(bus.d), 32'd12);
    chk("os1_busy", 32'(bus.busy), 32'd1);
    chk("os1_cet_load", 32'(bus.cet), 32'd0);
    tick(1);                                   // edge 1
    chk("os1_run_pe", 32'(bus.pe), 32'd1);
    chk("os1_run_cet", 32'(bus.cet), 32'd1);
    chk("os1_run_cep", 32'(bus.cep), 32'd1);
    chk("os1_q", 32'(q), 32'd12);
    tick(3);                                   // edge 4
    chk("os1_tc", 32'(bus.tc), 32'd1);
    chk("os1_done_early", 32'(bus.done), 32'd0);
    tick(1);                                   // edge 5
    chk("os1_done", 32'(bus.done), 32'd1);
    chk("os1_busy_fall", 32'(bus.busy), 32'd0);
    chk("os1_wraps", 32'(bus.wraps), 32'd1);
    tick(1);                                   // edge 6
    chk("os1_done_end", 32'(bus.done), 32'd0);

    // One-shot p=12 R=2, with an ignored start mid-RUN
    go(4'd12, 8'd2, 1'b0);
    tick(5);                                   // edge 5
    chk("os2_pe2", 32'(bus.pe), 32'd0);
    chk("os2_wraps1", 32'(bus.wraps), 32'd1);
    chk("os2_done_mid", 32'(bus.done), 32'd0);
    tick(2);                                   // edge 7
    bus.start = 1'b1; bus.preset = 4'd3; bus.rpt = 8'd9;
    tick(1);                                   // edge 8
    bus.start = 1'b0;
    chk("os2_start_ign_q", 32'(q), 32'd14);
    chk("os2_start_ign_d", 32'(bus.d), 32'd12);
    tick(1);                                   // edge 9
    chk("os2_done_early", 32'(bus.done), 32'd0);
    tick(1);                                   // edge 10
    chk("os2_done", 32'(bus.done), 32'd1);
    chk("os2_wraps2", 32'(bus.wraps), 32'd2);
    tick(1);
    chk("os2_done_end", 32'(bus.done), 32'd0);

    // Pause at Q=15 for 3 cycles, p=14 R=1
    go(4'd14, 8'd1, 1'b0);
    tick(2);                                   // edge 2, Q=15
    chk("pz_tc", 32'(bus.tc), 32'd1);
    bus.pause = 1'b1;
    #1;
    chk("pz_cep", 32'(bus.cep), 32'd0);
    tick(2);                                   // edge 4
    chk("pz_wraps", 32'(bus.wraps), 32'd0);
    chk("pz_busy", 32'(bus.busy), 32'd1);
    tick(1);                                   // edge 5
    bus.pause = 1'b0;
    chk("pz_done_early", 32'(bus.done), 32'd0);
    tick(1);                                   // edge 6
    chk("pz_done", 32'(bus.done), 32'd1);
    chk("pz_wraps1", 32'(bus.wraps), 32'd1);
    tick(1);

    // Periodic p=13 R=1
    go(4'd13, 8'd1, 1'b1);                     // edge 0
    chk("per_done0", 32'(bus.done), 32'd0);
    tick(4);                                   // edge 4
    chk("per_done4", 32'(bus.done), 32'd1);
    chk("per_pe4", 32'(bus.pe), 32'd0);
    chk("per_busy4", 32'(bus.busy), 32'd1);
    chk("per_wraps4", 32'(bus.wraps), 32'd0);
    tick(1);
    chk("per_done5", 32'(bus.done), 32'd0);
    tick(3);                                   // edge 8
    chk("per_done8", 32'(bus.done), 32'd1);
    chk("per_pe8", 32'(bus.pe), 32'd0);
    tick(1);                                   // edge 9, RUN
    bus.stop = 1'b1;
    tick(1);                                   // edge 10
    bus.stop = 1'b0;
    bus.mode = 1'b0;
    chk("per_stop_busy", 32'(bus.busy), 32'd0);
    chk("per_stop_pe", 32'(bus.pe), 32'd1);
    chk("per_stop_done", 32'(bus.done), 32'd0);
    tick(4);
    chk("per_no_done", 32'(bus.done), 32'd0);

    // repeat=0
    go(4'd5, 8'd0, 1'b0);
    chk("r0_done", 32'(bus.done), 32'd1);
    chk("r0_pe", 32'(bus.pe), 32'd1);
    chk("r0_busy", 32'(bus.busy), 32'd0);
    tick(1);
    chk("r0_done_end", 32'(bus.done), 32'd0);
    chk("r0_pe_end", 32'(bus.pe), 32'd1);

    // start and stop together
    bus.stop = 1'b1;
    go(4'd12, 8'd1, 1'b0);
    bus.stop = 1'b0;
    chk("ss_busy", 32'(bus.busy), 32'd0);
    chk("ss_pe", 32'(bus.pe), 32'd1);
    tick(1);
    chk("ss_busy2", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-RUN
    go(4'd12, 8'd2, 1'b0);
    tick(7);                                   // edge 7, RUN second segment
    chk("rr_cep_pre", 32'(bus.cep), 32'd1);
    chk("rr_wraps_pre", 32'(bus.wraps), 32'd1);
    #2;
    CR = 1'b0;
    #1;
    chk("rr_pe", 32'(bus.pe), 32'd1);
    chk("rr_cep", 32'(bus.cep), 32'd0);
    chk("rr_cet", 32'(bus.cet), 32'd0);
    chk("rr_busy", 32'(bus.busy), 32'd0);
    chk("rr_wraps", 32'(bus.wraps), 32'd0);
    tick(1);
    @(negedge CP);
    CR = 1'b1;
    tick(1);
    chk("rr_done_a", 32'(bus.done), 32'd0);
    tick(4);
    chk("rr_done_b", 32'(bus.done), 32'd0);
    chk("rr_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
